mem_stage: RTL and testbench

//  MEM pipeline stage, directly downstream of the EXE ALU. Registers the EXE result bundle and

---
 rtl/cpu_defs.sv | 53 +++++
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_align.sv | 50 +++++
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: basic word types, MEM-stage memory op and state encodings,
// exception codes, and small decode helpers used across the stage.
package cpu_defs;

  typedef logic [31:0] uint32_t;
  typedef logic [31:0] virt_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [2:0] {
    MS_IDLE   = 3'd0,
    MS_REQ    = 3'd1,
    MS_WAIT   = 3'd2,
    MS_DONE   = 3'd3,
    MS_CANCEL = 3'd4
  } ms_state_t;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  function automatic logic is_load(mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
  function automatic logic addr_misaligned(mem_op_t op, logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: bad = a[0];
      MEM_LW, MEM_SW:          bad = |a;
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// SRAM-like data bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
  import cpu_defs::*;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  uint32_t     data_addr;
  logic [3:0]  data_wstrb;
  uint32_t     data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  uint32_t     data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_align.sv
// Byte-lane alignment for the MEM stage: store size/strobe/data replication and
// load lane selection with sign or zero extension.
module mem_align
  import cpu_defs::*;
(
  input  mem_op_t     mem_op,
  input  logic [1:0]  addr_lo,
  input  uint32_t     rt_value,
  input  uint32_t     rdata,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output uint32_t     wdata,
  output uint32_t     load_res
);

  uint32_t     rshift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    rshift   = rdata >> {addr_lo, 3'b000};
    byte_sel = rshift[7:0];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    size     = 2'd2;
    wstrb    = 4'b0000;
    wdata    = rt_value;
    load_res = rdata;

    case (mem_op)
      MEM_LB:  begin size = 2'd0; load_res = {{24{byte_sel[7]}}, byte_sel}; end
      MEM_LBU: begin size = 2'd0; load_res = {24'd0, byte_sel}; end
      MEM_LH:  begin size = 2'd1; load_res = {{16{half_sel[15]}}, half_sel}; end
      MEM_LHU: begin size = 2'd1; load_res = {16'd0, half_sel}; end
      MEM_SB: begin
        size  = 2'd0;
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{rt_value[7:0]}};
      end
      MEM_SH: begin
        size  = 2'd1;
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rt_value[15:0]}};
      end
      MEM_SW:  wstrb = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EXE bundle, drives the data bus for loads/stores,
// and hands the aligned result or an address/overflow exception to WB.
//
//  state  | meaning
//  IDLE   | no bus transaction outstanding
//  REQ    | data_req asserted, waiting for addr_ok
//  WAIT   | address accepted, waiting for data_ok
//  DONE   | data returned (rdata latched), bundle ready for WB
//  CANCEL | flushed after address accept; swallow the pending data_ok
module mem_stage
  import cpu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es_valid,
  output logic              ms_allowin,
  input  logic [DATA_W-1:0] es_alu_res,
  input  logic              es_alu_ex,
  input  mem_op_t           es_mem_op,
  input  logic [DATA_W-1:0] es_rt_value,
  input  logic [REG_AW-1:0] es_dest,
  input  virt_t             es_pc,
  input  logic              flush,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [DATA_W-1:0] ms_result,
  output logic [REG_AW-1:0] ms_dest,
  output virt_t             ms_pc,
  output logic              ms_ex,
  output logic [4:0]        ms_excode,
  output virt_t             ms_badvaddr,
  output logic              ms_fwd_busy,
  mem_stage_if.master       bus
);

  ms_state_t         state, state_nxt;
  logic              ms_valid;
  mem_op_t           r_op;
  logic [DATA_W-1:0] r_alu_res, r_rt, r_rdata;
  logic              r_ex;
  logic [4:0]        r_excode;
  logic              es_addr_err, es_exc, es_mem_go;
  logic              capture, mem_active, ready_go, rdata_hit;
  uint32_t           load_res;

  assign es_addr_err = addr_misaligned(es_mem_op, es_alu_res[1:0]);
  assign es_exc      = es_alu_ex || es_addr_err;
  assign es_mem_go   = (es_mem_op != MEM_NONE) && !es_exc;

  // Excepting ops never touch the bus, so they complete like ALU ops.
  assign mem_active     = (r_op != MEM_NONE) && !r_ex;
  assign ready_go       = !mem_active || (state == MS_DONE);
  assign ms_allowin     = (state != MS_CANCEL) && (!ms_valid || (ready_go && ws_allowin));
  assign capture        = es_valid && ms_allowin && !flush;
  assign ms_to_ws_valid = ms_valid && ready_go && !flush;
  assign ms_fwd_busy    = ms_valid && is_load(r_op) && (state != MS_DONE);
  assign rdata_hit      = bus.data_data_ok &&
                          ((state == MS_WAIT) || ((state == MS_REQ) && bus.data_addr_ok));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= MS_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MS_IDLE: if (capture && es_mem_go) state_nxt = MS_REQ;
      MS_REQ: begin
        // An accepted address under flush still owes a data_ok unless it arrives now.
        if (flush) begin
          if (bus.data_addr_ok && !bus.data_data_ok) state_nxt = MS_CANCEL;
          else                                      state_nxt = MS_IDLE;
        end else if (bus.data_addr_ok) begin
          state_nxt = bus.data_data_ok ? MS_DONE : MS_WAIT;
        end
      end
      MS_WAIT: begin
        if (flush)                  state_nxt = bus.data_data_ok ? MS_IDLE : MS_CANCEL;
        else if (bus.data_data_ok) state_nxt = MS_DONE;
      end
      MS_DONE: begin
        if (flush)           state_nxt = MS_IDLE;
        else if (ms_allowin) state_nxt = (capture && es_mem_go) ? MS_REQ : MS_IDLE;
      end
      MS_CANCEL: if (bus.data_data_ok) state_nxt = MS_IDLE;
      default:   state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      r_op        <= MEM_NONE;
      r_alu_res   <= '0;
      r_rt        <= '0;
      r_rdata     <= '0;
      r_ex        <= 1'b0;
      r_excode    <= '0;
      ms_dest     <= '0;
      ms_pc       <= '0;
      ms_badvaddr <= '0;
    end else begin
      if (flush)           ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_valid;

      if (capture) begin
        r_op      <= es_mem_op;
        r_alu_res <= es_alu_res;
        r_rt      <= es_rt_value;
        r_ex      <= es_exc;
        ms_dest   <= es_dest;
        ms_pc     <= es_pc;
        if (es_alu_ex) begin
          r_excode    <= EXC_OV;
          ms_badvaddr <= '0;
        end else if (es_addr_err) begin
          r_excode    <= is_store(es_mem_op) ? EXC_ADES : EXC_ADEL;
          ms_badvaddr <= es_alu_res;
        end else begin
          r_excode    <= '0;
          ms_badvaddr <= '0;
        end
      end

      if (rdata_hit) r_rdata <= bus.data_rdata;
    end
  end

  mem_align u_align (
    .mem_op   (r_op),
    .addr_lo  (r_alu_res[1:0]),
    .rt_value (r_rt),
    .rdata    (r_rdata),
    .size     (bus.data_size),
    .wstrb    (bus.data_wstrb),
    .wdata    (bus.data_wdata),
    .load_res (load_res)
  );

  assign bus.data_req  = (state == MS_REQ);
  assign bus.data_wr   = is_store(r_op);
  assign bus.data_addr = r_alu_res;

  assign ms_result = (is_load(r_op) && !r_ex) ? load_res : r_alu_res;
  assign ms_ex     = r_ex;
  assign ms_excode = r_excode;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized ops against a behavioural model
// of lane selection, strobes, exceptions and handshake latency.
module tb_mem_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_valid, es_alu_ex, flush, ws_allowin;
  logic [31:0] es_alu_res, es_rt_value;
  mem_op_t     es_mem_op;
  logic [4:0]  es_dest;
  virt_t       es_pc;
  logic        ms_allowin, ms_to_ws_valid, ms_ex, ms_fwd_busy;
  logic [31:0] ms_result;
  logic [4:0]  ms_dest, ms_excode;
  virt_t       ms_pc, ms_badvaddr;

  int n_chk  = 0;
  int n_pass = 0;

  mem_stage_if bus();

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .es_valid(es_valid), .ms_allowin(ms_allowin),
    .es_alu_res(es_alu_res), .es_alu_ex(es_alu_ex), .es_mem_op(es_mem_op),
    .es_rt_value(es_rt_value), .es_dest(es_dest), .es_pc(es_pc),
    .flush(flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_result(ms_result), .ms_dest(ms_dest),
    .ms_pc(ms_pc), .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_badvaddr(ms_badvaddr),
    .ms_fwd_busy(ms_fwd_busy), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] ref_load(mem_op_t op, logic [31:0] a, logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (op)
      MEM_LB:  return (b >= 128)   ? (32'hFFFF_FF00 | b) : b;
      MEM_LBU: return b;
      MEM_LH:  return (h >= 32768) ? (32'hFFFF_0000 | h) : h;
      MEM_LHU: return h;
      default: return d;
    endcase
  endfunction

  function automatic int op_bytes(mem_op_t op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 1;
    endcase
  endfunction

  // One instruction through MEM with a slave that answers addr_ok after a_dly cycles
  // of request and data_ok d_dly cycles after that; WB stalls for 'stall' cycles.
  task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rdata, input logic ov,
                        input int a_dly, input int d_dly, input int stall);
    logic        ld, st, misal, e_ex, on_bus, got_req, done;
    logic [4:0]  e_code, dest;
    logic [31:0] e_res, e_bad, e_strb, e_wdata, e_size, pc;
    int          cnt, phase, dok_cyc;

    ld     = op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    st     = op inside {MEM_SB, MEM_SH, MEM_SW};
    misal  = (ld || st) && ((addr % op_bytes(op)) != 0);
    e_ex   = ov || misal;
    e_code = ov ? EXC_OV : (misal ? (ld ? EXC_ADEL : EXC_ADES) : 5'd0);
    e_bad  = (!ov && misal) ? addr : 32'd0;
    on_bus = (ld || st) && !e_ex;
    e_res  = ld ? ref_load(op, addr, rdata) : addr;
    e_size = (op_bytes(op) == 1) ? 0 : ((op_bytes(op) == 2) ? 1 : 2);
    case (op)
      MEM_SB:  begin e_strb = 1 << (addr % 4);             e_wdata = (rt & 32'hFF) * 32'h0101_0101; end
      MEM_SH:  begin e_strb = ((addr % 4) >= 2) ? 12 : 3;  e_wdata = (rt & 32'hFFFF) * 32'h0001_0001; end
      default: begin e_strb = 15;                          e_wdata = rt; end
    endcase
    dest = 5'($urandom);
    pc   = $urandom & 32'hFFFF_FFFC;

    @(negedge clk);
    #1 chk("allowin_idle", ms_allowin, 1);
    es_valid = 1; es_mem_op = op; es_alu_res = addr; es_rt_value = rt;
    es_alu_ex = ov; es_dest = dest; es_pc = pc; ws_allowin = 1;
    @(negedge clk);
    es_valid = 0;
    got_req = 0; done = 0; phase = 0; cnt = a_dly; dok_cyc = -100;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = $urandom;
      if (bus.data_req && phase == 0) begin
        got_req = 1;
        chk("req_addr", bus.data_addr, addr);
        chk("req_wr", bus.data_wr, st);
        chk("req_size", bus.data_size, e_size);
        if (st) begin
          chk("req_wstrb", bus.data_wstrb, e_strb);
          chk("req_wdata", bus.data_wdata, e_wdata);
        end
        if (cnt == 0) begin
          bus.data_addr_ok = 1;
          if (d_dly == 0) begin
            bus.data_data_ok = 1; bus.data_rdata = rdata; phase = 2; dok_cyc = cyc;
          end else begin
            phase = 1; cnt = d_dly;
          end
        end else cnt--;
      end else if (phase == 1) begin
        cnt--;
        if (cnt == 0) begin
          bus.data_data_ok = 1; bus.data_rdata = rdata; phase = 2; dok_cyc = cyc;
        end
      end
      #1;
      if (ms_to_ws_valid) begin
        done = 1;
        chk("latency", cyc, on_bus ? dok_cyc + 1 : 0);
        chk("ms_ex", ms_ex, e_ex);
        chk("ms_excode", ms_excode, e_code);
        chk("ms_dest", ms_dest, dest);
        chk("ms_pc", ms_pc, pc);
        if (!ov) chk("ms_badvaddr", ms_badvaddr, e_bad);
        if (!e_ex && !st) chk("ms_result", ms_result, e_res);
        if (!e_ex) chk("fwd_busy_done", ms_fwd_busy, 0);
        if (stall > 0) begin
          ws_allowin = 0;
          for (int s = 0; s < stall; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            chk("stall_valid", ms_to_ws_valid, 1);
            chk("stall_allowin", ms_allowin, 0);
            chk("stall_dest", ms_dest, dest);
            if (!e_ex && !st) chk("stall_result", ms_result, e_res);
          end
          ws_allowin = 1;
        end
      end else begin
        if (on_bus && ld) chk("fwd_busy_wait", ms_fwd_busy, 1);
        @(negedge clk);
      end
    end
    chk("ws_valid_seen", done, 1);
    chk("bus_req_issued", got_req, on_bus);
  endtask

  task automatic issue_lw(input logic [31:0] addr);
    @(negedge clk);
    es_valid = 1; es_mem_op = MEM_LW; es_alu_res = addr; es_alu_ex = 0; ws_allowin = 1;
    @(negedge clk);
    es_valid = 0;
  endtask

  task automatic flush_wait_test();
    issue_lw(32'h1000);
    bus.data_addr_ok = 1;
    #1 chk("fw_req", bus.data_req, 1);
    @(negedge clk);
    bus.data_addr_ok = 0; flush = 1;
    #1 chk("fw_flush_valid", ms_to_ws_valid, 0);
    @(negedge clk);
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("cancel_allowin", ms_allowin, 0);
      chk("cancel_valid", ms_to_ws_valid, 0);
      chk("cancel_req", bus.data_req, 0);
      @(negedge clk);
    end
    bus.data_data_ok = 1; bus.data_rdata = 32'h5555_AAAA;
    #1 chk("cancel_dok_allowin", ms_allowin, 0);
    @(negedge clk);
    bus.data_data_ok = 0;
    #1;
    chk("post_cancel_allowin", ms_allowin, 1);
    chk("post_cancel_valid", ms_to_ws_valid, 0);
    run_op(MEM_LW, 32'h1008, 32'h0, 32'hCAFE_F00D, 0, 0, 1, 0);
  endtask

  task automatic flush_req_test();
    issue_lw(32'h1010);
    flush = 1;
    #1;
    chk("fr_req", bus.data_req, 1);
    chk("fr_valid", ms_to_ws_valid, 0);
    @(negedge clk);
    flush = 0;
    #1;
    chk("fr_req_dropped", bus.data_req, 0);
    chk("fr_allowin", ms_allowin, 1);
  endtask

  initial begin
    resetn = 0; es_valid = 0; es_alu_ex = 0; flush = 0; ws_allowin = 1;
    es_alu_res = 0; es_rt_value = 0; es_mem_op = MEM_NONE; es_dest = 0; es_pc = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
    #12;
    chk("rst_valid", ms_to_ws_valid, 0);
    chk("rst_req", bus.data_req, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_result", ms_result, 0);
    chk("rst_ex", ms_ex, 0);
    chk("rst_busy", ms_fwd_busy, 0);
    @(negedge clk);
    resetn = 1;

    run_op(MEM_LW,   32'h1000, 32'h0,        32'hDEAD_BEEF, 0, 0, 2, 0);
    run_op(MEM_LB,   32'h1003, 32'h0,        32'h80FF_0000, 0, 1, 1, 0);
    run_op(MEM_LBU,  32'h1003, 32'h0,        32'h80FF_0000, 0, 0, 1, 0);
    run_op(MEM_LHU,  32'h1002, 32'h0,        32'h80FF_0000, 0, 0, 0, 0);
    run_op(MEM_SH,   32'h2002, 32'h1234_ABCD, 32'h0,        0, 2, 1, 0);
    run_op(MEM_LW,   32'h1002, 32'h0,        32'h0,         0, 0, 0, 0);
    run_op(MEM_SW,   32'h1001, 32'h0,        32'h0,         0, 0, 0, 0);
    run_op(MEM_NONE, 32'h7777_0001, 32'h0,   32'h0,         0, 0, 0, 3);
    run_op(MEM_LW,   32'h1002, 32'h0,        32'h0,         1, 0, 0, 0);
    run_op(MEM_LW,   32'h1004, 32'h0,        32'h0BAD_F00D, 0, 0, 0, 3);
    flush_wait_test();
    flush_req_test();

    for (int i = 0; i < 80; i++) begin
      mem_op_t     op;
      logic [31:0] addr;
      op   = mem_op_t'(4'($urandom_range(0, 8)));
      addr = 32'h0000_4000 + $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % op_bytes(op));
      run_op(op, addr, $urandom, $urandom, ($urandom_range(0, 9) == 0),
             $urandom_range(0, 2), $urandom_range(0, 3),
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
